// File: rtl/shift_arbiter_if.sv
// Bundles the requester-side and shifter-side signals of shift_arbiter.
// master = the arbiter's view; slave = the requesters plus the shifter.
interface shift_arbiter_if #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned DATA_WIDTH = 64
);
    logic [NUM_REQ-1:0]            req_stb;
    logic [NUM_REQ-1:0]            req_arith;
    logic [NUM_REQ-1:0]            req_left;
    logic [NUM_REQ-1:0]            req_alu32;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_value;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_shift;
    logic [NUM_REQ-1:0]            req_ack;
    logic [DATA_WIDTH-1:0]         req_out;
    logic                          sh_stb;
    logic                          sh_arith;
    logic                          sh_left;
    logic [DATA_WIDTH-1:0]         sh_value;
    logic [DATA_WIDTH-1:0]         sh_shift;
    logic [DATA_WIDTH-1:0]         sh_out;
    logic                          sh_ack;
    logic                          busy;
    logic                          err_timeout;

    modport master (
        input  req_stb, req_arith, req_left, req_alu32, req_value, req_shift, sh_out, sh_ack,
        output req_ack, req_out, sh_stb, sh_arith, sh_left, sh_value, sh_shift, busy,
        output err_timeout
    );

    modport slave (
        output req_stb, req_arith, req_left, req_alu32, req_value, req_shift, sh_out, sh_ack,
        input  req_ack, req_out, sh_stb, sh_arith, sh_left, sh_value, sh_shift, busy,
        input  err_timeout
    );
endinterface

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one multi-cycle 64-bit shifter between NUM_REQ requesters,
// applying eBPF shift-amount masking and 32-bit sub-word operand/result rules.
module shift_arbiter #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    shift_arbiter_if.master bus
);
    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned TmrW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {StDrain, StIdle, StIssue, StWait, StResp} state_e;

    state_e                state_q, state_d;
    logic [1:0]            drain_q, drain_d;
    logic [IdxW-1:0]       rr_q, rr_d;
    logic [IdxW-1:0]       grant_q, grant_d;
    logic                  arith_q, arith_d;
    logic                  left_q, left_d;
    logic                  alu32_q, alu32_d;
    logic [DATA_WIDTH-1:0] value_q, value_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] res_q, res_d;
    logic [TmrW-1:0]       tmr_q, tmr_d;
    logic                  err_q, err_d;

    logic                  any_req;
    logic [IdxW-1:0]       win;
    logic [IdxW-1:0]       cand;
    logic                  w_left, w_alu32, op_arith;
    logic [DATA_WIDTH-1:0] w_value, w_shift, op_value, op_shift;

    // First requester at or above the rr pointer, wrapping at NUM_REQ.
    always_comb begin
        any_req = 1'b0;
        win     = rr_q;
        cand    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = IdxW'((32'(rr_q) + k) % NUM_REQ);
            if (!any_req && bus.req_stb[cand]) begin
                any_req = 1'b1;
                win     = cand;
            end
        end
    end

    always_comb begin
        w_left   = bus.req_left[win];
        w_alu32  = bus.req_alu32[win];
        w_value  = bus.req_value[win*DATA_WIDTH +: DATA_WIDTH];
        w_shift  = bus.req_shift[win*DATA_WIDTH +: DATA_WIDTH];
        op_arith = bus.req_arith[win] & ~w_left;
        if (w_alu32) begin
            op_shift = DATA_WIDTH'(w_shift[4:0]);
            // Sign-extend only for arithmetic right so the upper half shifts in the sign.
            op_value = op_arith ? {{(DATA_WIDTH-32){w_value[31]}}, w_value[31:0]}
                                : {{(DATA_WIDTH-32){1'b0}}, w_value[31:0]};
        end else begin
            op_shift = DATA_WIDTH'(w_shift[5:0]);
            op_value = w_value;
        end
    end

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        rr_d    = rr_q;
        grant_d = grant_q;
        arith_d = arith_q;
        left_d  = left_q;
        alu32_d = alu32_q;
        value_d = value_q;
        shift_d = shift_q;
        res_d   = res_q;
        tmr_d   = tmr_q;
        err_d   = err_q;
        case (state_q)
            StDrain: begin
                drain_d = drain_q - 2'd1;
                if (drain_q == 2'd1) state_d = StIdle;
            end
            StIdle: begin
                if (any_req) begin
                    grant_d = win;
                    arith_d = op_arith;
                    left_d  = w_left;
                    alu32_d = w_alu32;
                    value_d = op_value;
                    shift_d = op_shift;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                tmr_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                if (bus.sh_ack) begin
                    res_d   = alu32_q ? {{(DATA_WIDTH-32){1'b0}}, bus.sh_out[31:0]} : bus.sh_out;
                    state_d = StResp;
                end else if (tmr_q == TmrW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    res_d   = '0;
                    state_d = StResp;
                end else begin
                    tmr_d = tmr_q + TmrW'(1);
                end
            end
            StResp: begin
                rr_d    = (grant_q == IdxW'(NUM_REQ - 1)) ? '0 : grant_q + IdxW'(1);
                state_d = StIdle;
            end
            default: state_d = StDrain;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StDrain;
            drain_q <= 2'd3;
            rr_q    <= '0;
            grant_q <= '0;
            arith_q <= 1'b0;
            left_q  <= 1'b0;
            alu32_q <= 1'b0;
            value_q <= '0;
            shift_q <= '0;
            res_q   <= '0;
            tmr_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            arith_q <= arith_d;
            left_q  <= left_d;
            alu32_q <= alu32_d;
            value_q <= value_d;
            shift_q <= shift_d;
            res_q   <= res_d;
            tmr_q   <= tmr_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        bus.req_ack = '0;
        if (state_q == StResp) bus.req_ack[grant_q] = 1'b1;
    end

    assign bus.req_out     = (state_q == StResp) ? res_q : '0;
    assign bus.sh_stb      = (state_q == StIssue);
    assign bus.sh_arith    = arith_q;
    assign bus.sh_left     = left_q;
    assign bus.sh_value    = value_q;
    assign bus.sh_shift    = shift_q;
    assign bus.busy        = (state_q != StIdle);
    assign bus.err_timeout = err_q;
endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: directed table, random ops against an eBPF shift model,
// and hand sequences for round-robin, timeout and mid-operation reset.
module tb_shift_arbiter;
    localparam int unsigned NR = 2;
    localparam int unsigned DW = 64;
    localparam int unsigned TO = 15;

    logic clk = 1'b0;
    logic rst_n;

    shift_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

    shift_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // Shifter model: acks two cycles after sh_stb, no reset.
    logic d1 = 1'b0, ack_q = 1'b0, ack_en = 1'b1, force_ack = 1'b0;
    always @(posedge clk) begin
        d1    <= bus.sh_stb;
        ack_q <= d1;
    end
    assign bus.sh_ack = (ack_q & ack_en) | force_ack;
    always_comb begin
        if (bus.sh_left)       bus.sh_out = bus.sh_value << bus.sh_shift[5:0];
        else if (bus.sh_arith) bus.sh_out = $unsigned($signed(bus.sh_value) >>> bus.sh_shift[5:0]);
        else                   bus.sh_out = bus.sh_value >> bus.sh_shift[5:0];
    end

    // eBPF result semantics computed directly on the requested width.
    function automatic logic [63:0] ref_result(bit ar, bit le, bit a32, logic [63:0] v,
                                               logic [63:0] s);
        int unsigned        amt;
        logic [31:0]        v32;
        logic signed [31:0] sv;
        logic [31:0]        r32;
        if (a32) begin
            amt = int'(s % 64'd32);
            v32 = v[31:0];
            sv  = v32;
            if (le)      r32 = v32 << amt;
            else if (ar) r32 = sv >>> amt;
            else         r32 = v32 >> amt;
            return {32'b0, r32};
        end
        amt = int'(s % 64'd64);
        if (le) return v << amt;
        if (ar) return $unsigned($signed(v) >>> amt);
        return v >> amt;
    endfunction

    function automatic logic [63:0] ref_amt(bit a32, logic [63:0] s);
        return a32 ? (s % 64'd32) : (s % 64'd64);
    endfunction

    function automatic logic [63:0] ref_value(bit ar, bit le, bit a32, logic [63:0] v);
        logic [63:0] lo;
        lo = v % 64'h1_0000_0000;
        if (!a32) return v;
        if (ar && !le && (lo >= 64'h8000_0000)) return lo + 64'hFFFF_FFFF_0000_0000;
        return lo;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_stb(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.sh_stb) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_ack(input int lim, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < lim; k++) begin
            @(negedge clk);
            if (bus.req_ack != '0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_op(input string name, input int idx, input bit ar, input bit le,
                         input bit a32, input logic [63:0] v, input logic [63:0] s,
                         input logic [63:0] exp_out, input logic [63:0] exp_amt,
                         input logic [63:0] exp_val);
        bit ok;
        int t0;
        logic [1:0] exp_ack;
        @(negedge clk);
        bus.req_arith[idx]            = ar;
        bus.req_left[idx]             = le;
        bus.req_alu32[idx]            = a32;
        bus.req_value[idx*64 +: 64]   = v;
        bus.req_shift[idx*64 +: 64]   = s;
        bus.req_stb[idx]              = 1'b1;
        wait_stb(ok);
        check({name, " stb_seen"}, 64'(ok), 64'd1);
        if (!ok) begin
            bus.req_stb[idx] = 1'b0;
            return;
        end
        t0 = cyc;
        check({name, " sh_shift"}, bus.sh_shift, exp_amt);
        check({name, " sh_value"}, bus.sh_value, exp_val);
        check({name, " sh_arith"}, 64'(bus.sh_arith), 64'(ar & ~le));
        check({name, " sh_left"}, 64'(bus.sh_left), 64'(le));
        wait_ack(40, ok);
        check({name, " ack_seen"}, 64'(ok), 64'd1);
        exp_ack = 2'b01 << idx;
        check({name, " req_ack"}, 64'(bus.req_ack), 64'(exp_ack));
        check({name, " req_out"}, bus.req_out, exp_out);
        check({name, " latency"}, 64'(cyc - t0), 64'd3);
        bus.req_stb[idx] = 1'b0;
    endtask

    typedef struct {
        int          idx;
        bit          ar, le, a32;
        logic [63:0] v, s, out, amt, val;
    } vec_t;

    vec_t vecs[7];

    initial begin
        bit ok;
        int prev;
        int t0;
        vecs[0] = '{0, 0, 1, 0, 64'h1, 64'h43, 64'h8, 64'd3, 64'h1};
        vecs[1] = '{1, 1, 0, 1, 64'hFFFF_FFFF_8000_0000, 64'd4, 64'h0000_0000_F800_0000, 64'd4,
                    64'hFFFF_FFFF_8000_0000};
        vecs[2] = '{0, 0, 0, 1, 64'hDEAD_BEEF_8000_0000, 64'h3F, 64'h1, 64'd31,
                    64'h0000_0000_8000_0000};
        vecs[3] = '{1, 1, 0, 0, 64'h8000_0000_0000_0000, 64'd4, 64'hF800_0000_0000_0000, 64'd4,
                    64'h8000_0000_0000_0000};
        vecs[4] = '{0, 0, 0, 0, 64'hF0, 64'h44, 64'hF, 64'd4, 64'hF0};
        vecs[5] = '{1, 0, 1, 1, 64'h1234_5678_8000_0001, 64'h21, 64'h2, 64'd1,
                    64'h0000_0000_8000_0001};
        vecs[6] = '{0, 1, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd4, 64'h0000_0000_FFFF_FFF0, 64'd4,
                    64'h0000_0000_FFFF_FFFF};

        // Both requesters held from reset: req0 1<<1, req1 0x100>>4.
        rst_n         = 1'b0;
        bus.req_arith = '0;
        bus.req_left  = 2'b01;
        bus.req_alu32 = '0;
        bus.req_value = {64'h100, 64'h1};
        bus.req_shift = {64'd4, 64'd1};
        bus.req_stb   = 2'b11;
        repeat (2) @(negedge clk);
        check("rst busy", 64'(bus.busy), 64'd1);
        check("rst sh_stb", 64'(bus.sh_stb), 64'd0);
        check("rst req_ack", 64'(bus.req_ack), 64'd0);
        check("rst req_out", bus.req_out, 64'd0);
        check("rst sh_value", bus.sh_value, 64'd0);
        check("rst err", 64'(bus.err_timeout), 64'd0);

        rst_n = 1'b1;
        check("drain0 sh_stb", 64'(bus.sh_stb), 64'd0);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check($sformatf("drain%0d busy", i), 64'(bus.busy), (i < 3) ? 64'd1 : 64'd0);
            check($sformatf("drain%0d sh_stb", i), 64'(bus.sh_stb), 64'd0);
        end
        @(negedge clk);
        check("first grant sh_stb", 64'(bus.sh_stb), 64'd1);

        prev = 0;
        for (int g = 0; g < 4; g++) begin
            wait_ack(20, ok);
            check($sformatf("rr%0d ack_seen", g), 64'(ok), 64'd1);
            check($sformatf("rr%0d req_ack", g), 64'(bus.req_ack), (g % 2 == 1) ? 64'd2 : 64'd1);
            check($sformatf("rr%0d req_out", g), bus.req_out, (g % 2 == 1) ? 64'h10 : 64'h2);
            if (g > 0) check($sformatf("rr%0d spacing", g), 64'(cyc - prev), 64'd5);
            prev = cyc;
        end
        bus.req_stb = '0;

        foreach (vecs[i]) begin
            do_op($sformatf("vec%0d", i), vecs[i].idx, vecs[i].ar, vecs[i].le, vecs[i].a32,
                  vecs[i].v, vecs[i].s, vecs[i].out, vecs[i].amt, vecs[i].val);
        end

        for (int n = 0; n < 40; n++) begin
            int          idx;
            bit          ar, le, a32;
            logic [63:0] v, s;
            idx = int'($urandom_range(0, NR - 1));
            ar  = 1'($urandom);
            le  = 1'($urandom);
            a32 = 1'($urandom);
            v   = {$urandom, $urandom};
            s   = {$urandom, $urandom};
            do_op($sformatf("rnd%0d", n), idx, ar, le, a32, v, s, ref_result(ar, le, a32, v, s),
                  ref_amt(a32, s), ref_value(ar, le, a32, v));
        end

        // Shifter never acks: timeout, zero result, next request still served.
        ack_en = 1'b0;
        @(negedge clk);
        bus.req_left[0]         = 1'b1;
        bus.req_alu32[0]        = 1'b0;
        bus.req_value[0 +: 64]  = 64'd5;
        bus.req_shift[0 +: 64]  = 64'd1;
        bus.req_stb[0]          = 1'b1;
        wait_stb(ok);
        check("to stb_seen", 64'(ok), 64'd1);
        t0 = cyc;
        check("to err_before", 64'(bus.err_timeout), 64'd0);
        wait_ack(40, ok);
        check("to ack_seen", 64'(ok), 64'd1);
        check("to err", 64'(bus.err_timeout), 64'd1);
        check("to req_ack", 64'(bus.req_ack), 64'd1);
        check("to req_out", bus.req_out, 64'd0);
        check("to delay", 64'(cyc - t0), 64'(TO + 1));
        bus.req_stb[0] = 1'b0;
        ack_en = 1'b1;
        do_op("after_to", 1, 0, 1, 0, 64'h3, 64'd2, 64'hC, 64'd2, 64'h3);
        check("err sticky", 64'(bus.err_timeout), 64'd1);

        // Reset during WAIT, stray ack in DRAIN.
        ack_en = 1'b0;
        @(negedge clk);
        bus.req_left[1]          = 1'b0;
        bus.req_arith[1]         = 1'b0;
        bus.req_alu32[1]         = 1'b0;
        bus.req_value[64 +: 64]  = 64'h80;
        bus.req_shift[64 +: 64]  = 64'd3;
        bus.req_stb[1]           = 1'b1;
        wait_stb(ok);
        check("ab stb_seen", 64'(ok), 64'd1);
        @(negedge clk);
        rst_n       = 1'b0;
        bus.req_stb = '0;
        @(negedge clk);
        check("ab rst busy", 64'(bus.busy), 64'd1);
        check("ab rst err", 64'(bus.err_timeout), 64'd0);
        check("ab rst req_ack", 64'(bus.req_ack), 64'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            force_ack = (i == 1);
            check($sformatf("ab%0d busy", i), 64'(bus.busy), (i < 3) ? 64'd1 : 64'd0);
            check($sformatf("ab%0d req_ack", i), 64'(bus.req_ack), 64'd0);
        end
        force_ack = 1'b0;
        ack_en    = 1'b1;
        do_op("after_ab", 1, 1, 0, 1, 64'h0000_0000_8000_0010, 64'h24, 64'h0000_0000_F800_0001,
              64'd4, 64'hFFFF_FFFF_8000_0010);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
